// File: rtl/cineraria_core_nios2_fast_cpu_debug_ocimem_seq.sv
// Debug OCI memory sequencer: executes JTAG address/read/write commands against a
// local monitor RAM and shares that RAM with a CPU Avalon-MM slave, JTAG first.
module cineraria_core_nios2_fast_cpu_debug_ocimem_seq #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    input  logic              av_debugaccess,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {IDLE, J_RD1, J_RD2, C_RD1, C_RD2} state_t;
    typedef enum logic [1:0] {CMD_A, CMD_B, CMD_N} cmd_t;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] mem_rdata;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic              pend_vld_q, pend_vld_d;
    cmd_t              pend_cmd_q, pend_cmd_d;
    logic [37:0]       pend_jdo_q, pend_jdo_d;
    logic [31:0]       mon_q, mon_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;

    logic              pulse_any, pulse_multi;
    cmd_t              pulse_cmd;
    logic              exec_vld;
    cmd_t              exec_cmd;
    logic [37:0]       exec_jdo;
    logic              cpu_ok, cpu_wr_done, set_err;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              unused_jdo_bits;

    always_comb begin
        pulse_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        pulse_multi = (take_action_ocimem_a & take_action_ocimem_b)
                    | (take_action_ocimem_a & take_no_action_ocimem_a)
                    | (take_action_ocimem_b & take_no_action_ocimem_a);
        pulse_cmd   = take_action_ocimem_a ? CMD_A : (take_action_ocimem_b ? CMD_B : CMD_N);
    end

    always_comb begin
        state_d     = state_q;
        jaddr_d     = jaddr_q;
        pend_vld_d  = pend_vld_q;
        pend_cmd_d  = pend_cmd_q;
        pend_jdo_d  = pend_jdo_q;
        mon_d       = mon_q;
        rdata_d     = rdata_q;
        ready_d     = ready_q;
        error_d     = error_q;
        exec_vld    = 1'b0;
        exec_cmd    = pend_cmd_q;
        exec_jdo    = pend_jdo_q;
        cpu_ok      = 1'b0;
        cpu_wr_done = 1'b0;
        set_err     = pulse_multi;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_waddr   = '0;
        mem_raddr   = '0;
        mem_wdata   = '0;
        mem_be      = '0;

        // A pending command always runs before a fresh pulse; the fresh pulse refills the slot.
        if (state_q == IDLE) begin
            if (pend_vld_q) begin
                exec_vld   = 1'b1;
                pend_vld_d = pulse_any;
                pend_cmd_d = pulse_cmd;
                pend_jdo_d = jdo;
            end else if (pulse_any) begin
                exec_vld = 1'b1;
                exec_cmd = pulse_cmd;
                exec_jdo = jdo;
            end else begin
                cpu_ok = 1'b1;
            end
        end else if (pulse_any) begin
            if (pend_vld_q) begin
                set_err = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_cmd_d = pulse_cmd;
                pend_jdo_d = jdo;
            end
        end

        if (exec_vld) begin
            case (exec_cmd)
                CMD_A: begin
                    jaddr_d = exec_jdo[ADDR_W+16:17];
                    if (exec_jdo[25]) error_d = 1'b0;
                    if (exec_jdo[35]) begin
                        ready_d = 1'b0;
                        state_d = J_RD1;
                    end else begin
                        ready_d = 1'b1;
                    end
                end
                CMD_B: begin
                    mem_we    = 1'b1;
                    mem_waddr = jaddr_q;
                    mem_wdata = exec_jdo[34:3];
                    mem_be    = 4'hF;
                    jaddr_d   = jaddr_q + ADDR_W'(1);
                    ready_d   = 1'b1;
                end
                default: begin
                    ready_d = 1'b0;
                    state_d = J_RD1;
                end
            endcase
        end

        if (cpu_ok) begin
            if (av_write) begin
                cpu_wr_done = 1'b1;
                mem_we      = av_debugaccess;
                mem_waddr   = av_address;
                mem_wdata   = av_writedata;
                mem_be      = av_byteenable;
            end else if (av_read) begin
                mem_re    = 1'b1;
                mem_raddr = av_address;
                state_d   = C_RD1;
            end
        end

        case (state_q)
            J_RD1: begin
                mem_re    = 1'b1;
                mem_raddr = jaddr_q;
                state_d   = J_RD2;
            end
            J_RD2: begin
                mon_d   = mem_rdata;
                ready_d = 1'b1;
                jaddr_d = jaddr_q + ADDR_W'(1);
                state_d = IDLE;
            end
            C_RD1: begin
                rdata_d = mem_rdata;
                state_d = C_RD2;
            end
            C_RD2:   state_d = IDLE;
            default: ;
        endcase

        if (set_err) error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            jaddr_q    <= '0;
            pend_vld_q <= 1'b0;
            pend_cmd_q <= CMD_A;
            pend_jdo_q <= '0;
            mon_q      <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            jaddr_q    <= jaddr_d;
            pend_vld_q <= pend_vld_d;
            pend_cmd_q <= pend_cmd_d;
            pend_jdo_q <= pend_jdo_d;
            mon_q      <= mon_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    // Monitor RAM: contents survive reset, read data appears one cycle after the address.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
        if (mem_re) mem_rdata <= mem[mem_raddr];
    end

    assign av_waitrequest  = (av_read | av_write) & ~(cpu_wr_done | (state_q == C_RD2));
    assign av_readdata     = rdata_q;
    assign MonDReg         = mon_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;
    assign unused_jdo_bits = ^{exec_jdo[37:36], exec_jdo[2:0]};

endmodule

// File: tb/tb_cineraria_core_nios2_fast_cpu_debug_ocimem_seq.sv
// Bench for the debug OCI memory sequencer: directed vector table, hand-written
// pending/priority sequences, then random traffic against a behavioural model.
module tb_cineraria_core_nios2_fast_cpu_debug_ocimem_seq;

    localparam int AW = 8;
    localparam int OP_A = 0, OP_B = 1, OP_N = 2, OP_CW = 3, OP_CR = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [37:0]   jdo;
    logic          ta, tb_b, tn;
    logic [AW-1:0] av_address;
    logic          av_read, av_write;
    logic [31:0]   av_writedata;
    logic [3:0]    av_byteenable;
    logic          av_debugaccess;
    logic [31:0]   av_readdata;
    logic          av_waitrequest;
    logic [31:0]   MonDReg;
    logic          monitor_ready, monitor_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cineraria_core_nios2_fast_cpu_debug_ocimem_seq #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta),
        .take_action_ocimem_b    (tb_b),
        .take_no_action_ocimem_a (tn),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_debugaccess          (av_debugaccess),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    typedef struct {
        int          op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          dbg;
        bit          rd;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] ram_m [0:255];
    logic [7:0]  jaddr_m;
    logic [31:0] mon_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] ja(input logic [7:0] a, input bit rd, input bit clr);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        j[25] = clr;
        j[35] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jb(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    function automatic void add(input int op, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] be, input bit dbg, input bit rd,
                                input logic [31:0] exp);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.be = be; v.dbg = dbg; v.rd = rd; v.exp = exp;
        vecs.push_back(v);
    endfunction

    // One JTAG pulse, then wait (bounded) for the command to report completion.
    task automatic do_pulse(input int kind, input logic [37:0] j, output logic rdy);
        @(negedge clk);
        jdo = j;
        ta = (kind == OP_A); tb_b = (kind == OP_B); tn = (kind == OP_N);
        @(negedge clk);
        ta = 1'b0; tb_b = 1'b0; tn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (monitor_ready) break;
            @(negedge clk);
        end
        rdy = monitor_ready;
    endtask

    task automatic do_cw(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                         input bit dbg, output int cyc);
        @(negedge clk);
        av_address = a; av_writedata = d; av_byteenable = be; av_debugaccess = dbg;
        av_write = 1'b1;
        cyc = 1;
        #1;
        while (av_waitrequest && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        @(negedge clk);
        av_write = 1'b0;
    endtask

    task automatic do_cr(input logic [7:0] a, output logic [31:0] d, output int cyc);
        @(negedge clk);
        av_address = a; av_read = 1'b1;
        cyc = 1;
        #1;
        while (av_waitrequest && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        d = av_readdata;
        @(negedge clk);
        av_read = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        rdy;
        logic [31:0] d;
        int          cyc;

        reset_n = 1'b0; jdo = '0; ta = 0; tb_b = 0; tn = 0;
        av_address = '0; av_read = 0; av_write = 0; av_writedata = '0;
        av_byteenable = '0; av_debugaccess = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mon", MonDReg, 32'h0);
        check("rst_ready", {31'b0, monitor_ready}, 32'h0);
        check("rst_error", {31'b0, monitor_error}, 32'h0);
        check("rst_wait", {31'b0, av_waitrequest}, 32'h0);
        check("rst_avrd", av_readdata, 32'h0);

        // op, addr, data, be, dbg, rd, expected MonDReg / readdata
        add(OP_A,  8'h10, 0, 0, 0, 0, 32'h0);
        add(OP_B,  0, 32'hDEADBEEF, 0, 0, 0, 32'h0);
        add(OP_B,  0, 32'h12345678, 0, 0, 0, 32'h0);
        add(OP_B,  0, 32'hCAFEF00D, 0, 0, 0, 32'h0);
        add(OP_A,  8'h10, 0, 0, 0, 1, 32'hDEADBEEF);
        add(OP_N,  0, 0, 0, 0, 0, 32'h12345678);
        add(OP_N,  0, 0, 0, 0, 0, 32'hCAFEF00D);
        add(OP_A,  8'hFF, 0, 0, 0, 0, 32'hCAFEF00D);
        add(OP_B,  0, 32'h11111111, 0, 0, 0, 32'hCAFEF00D);
        add(OP_B,  0, 32'h22222222, 0, 0, 0, 32'hCAFEF00D);
        add(OP_A,  8'hFF, 0, 0, 0, 1, 32'h11111111);
        add(OP_N,  0, 0, 0, 0, 0, 32'h22222222);
        add(OP_A,  8'h30, 0, 0, 0, 0, 32'h22222222);
        add(OP_B,  0, 32'hFFFFFFFF, 0, 0, 0, 32'h22222222);
        add(OP_CW, 8'h30, 32'hAAAA5555, 4'b0011, 1, 0, 0);
        add(OP_CR, 8'h30, 0, 0, 0, 0, 32'hFFFF5555);
        add(OP_CW, 8'h30, 32'h0F0F0F0F, 4'b1111, 0, 0, 0);
        add(OP_CR, 8'h30, 0, 0, 0, 0, 32'hFFFF5555);
        add(OP_CR, 8'h10, 0, 0, 0, 0, 32'hDEADBEEF);
        add(OP_CR, 8'h00, 0, 0, 0, 0, 32'h22222222);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            case (v.op)
                OP_A, OP_B, OP_N: begin
                    if (v.op == OP_A)      do_pulse(OP_A, ja(v.addr, v.rd, 1'b0), rdy);
                    else if (v.op == OP_B) do_pulse(OP_B, jb(v.data), rdy);
                    else                   do_pulse(OP_N, '0, rdy);
                    check($sformatf("vec%0d_ready", i), {31'b0, rdy}, 32'h1);
                    check($sformatf("vec%0d_mon", i), MonDReg, v.exp);
                end
                OP_CW: begin
                    do_cw(v.addr, v.data, v.be, v.dbg, cyc);
                    check($sformatf("vec%0d_cw_cycles", i), cyc, 32'd1);
                end
                default: begin
                    do_cr(v.addr, d, cyc);
                    check($sformatf("vec%0d_cr_cycles", i), cyc, 32'd3);
                    check($sformatf("vec%0d_cr_data", i), d, v.exp);
                end
            endcase
        end

        // Read latency: data lands exactly two edges after the pulse edge.
        @(negedge clk);
        jdo = ja(8'h11, 1'b1, 1'b0); ta = 1'b1;
        @(negedge clk);
        ta = 1'b0;
        check("lat_k_ready", {31'b0, monitor_ready}, 32'h0);
        @(negedge clk);
        check("lat_k1_ready", {31'b0, monitor_ready}, 32'h0);
        check("lat_k1_mon", MonDReg, 32'h22222222);
        @(negedge clk);
        check("lat_k2_ready", {31'b0, monitor_ready}, 32'h1);
        check("lat_k2_mon", MonDReg, 32'h12345678);

        // JTAG write arriving during a CPU read is held, a second one overflows.
        do_pulse(OP_A, ja(8'h20, 1'b0, 1'b0), rdy);
        @(negedge clk);
        av_address = 8'h10; av_read = 1'b1;
        @(negedge clk);
        jdo = jb(32'h5A5A5A5A); tb_b = 1'b1;
        @(negedge clk);
        tb_b = 1'b0; jdo = ja(8'h40, 1'b0, 1'b0); ta = 1'b1;
        #1;
        check("pend_cr_wait", {31'b0, av_waitrequest}, 32'h0);
        check("pend_cr_data", av_readdata, 32'hDEADBEEF);
        @(negedge clk);
        ta = 1'b0; av_read = 1'b0; jdo = 38'h3F_FFFF_FFFF;
        @(negedge clk);
        check("pend_error", {31'b0, monitor_error}, 32'h1);
        do_pulse(OP_B, jb(32'h77777777), rdy);
        do_pulse(OP_A, ja(8'h21, 1'b1, 1'b0), rdy);
        check("pend_drop_mon", MonDReg, 32'h77777777);
        do_pulse(OP_A, ja(8'h20, 1'b1, 1'b0), rdy);
        check("pend_wr_mon", MonDReg, 32'h5A5A5A5A);
        check("pend_error_kept", {31'b0, monitor_error}, 32'h1);
        do_pulse(OP_A, ja(8'h00, 1'b0, 1'b1), rdy);
        check("err_clear", {31'b0, monitor_error}, 32'h0);

        // Simultaneous a and b: a wins, error flagged.
        @(negedge clk);
        jdo = ja(8'h21, 1'b0, 1'b0); ta = 1'b1; tb_b = 1'b1;
        @(negedge clk);
        ta = 1'b0; tb_b = 1'b0;
        check("multi_error", {31'b0, monitor_error}, 32'h1);
        do_pulse(OP_N, '0, rdy);
        check("multi_a_won", MonDReg, 32'h77777777);
        do_pulse(OP_A, ja(8'h00, 1'b0, 1'b1), rdy);

        // JTAG pulse beats a simultaneous CPU write; the write completes next cycle.
        @(negedge clk);
        av_address = 8'h30; av_writedata = 32'h0; av_byteenable = 4'hF;
        av_debugaccess = 1'b1; av_write = 1'b1;
        jdo = ja(8'h60, 1'b0, 1'b0); ta = 1'b1;
        #1;
        check("prio_wait_hi", {31'b0, av_waitrequest}, 32'h1);
        @(negedge clk);
        ta = 1'b0;
        #1;
        check("prio_wait_lo", {31'b0, av_waitrequest}, 32'h0);
        @(negedge clk);
        av_write = 1'b0;
        do_cr(8'h30, d, cyc);
        check("prio_wr_data", d, 32'h0);

        // Random traffic against the model.
        do_pulse(OP_A, ja(8'h00, 1'b0, 1'b0), rdy);
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            ram_m[i] = d;
            do_pulse(OP_B, jb(d), rdy);
        end
        do_pulse(OP_A, ja(8'h00, 1'b1, 1'b0), rdy);
        mon_m = ram_m[0];
        jaddr_m = 8'h01;
        check("rnd_start_mon", MonDReg, mon_m);
        for (int i = 0; i < 250; i++) begin
            int          op;
            logic [7:0]  a;
            logic [31:0] dv;
            logic [3:0]  be;
            bit          flag;
            op = $urandom_range(0, 4);
            a = 8'($urandom);
            dv = $urandom;
            be = 4'($urandom);
            flag = 1'($urandom);
            case (op)
                OP_A: begin
                    do_pulse(OP_A, ja(a, flag, 1'b0), rdy);
                    jaddr_m = a;
                    if (flag) begin
                        mon_m = ram_m[a];
                        jaddr_m = a + 8'd1;
                    end
                    check($sformatf("rnd%0d_a_mon", i), MonDReg, mon_m);
                end
                OP_B: begin
                    do_pulse(OP_B, jb(dv), rdy);
                    ram_m[jaddr_m] = dv;
                    jaddr_m = jaddr_m + 8'd1;
                    check($sformatf("rnd%0d_b_ready", i), {31'b0, rdy}, 32'h1);
                end
                OP_N: begin
                    do_pulse(OP_N, '0, rdy);
                    mon_m = ram_m[jaddr_m];
                    jaddr_m = jaddr_m + 8'd1;
                    check($sformatf("rnd%0d_n_mon", i), MonDReg, mon_m);
                end
                OP_CW: begin
                    do_cw(a, dv, be, flag, cyc);
                    if (flag) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) ram_m[a][8*b +: 8] = dv[8*b +: 8];
                    end
                    check($sformatf("rnd%0d_cw_cycles", i), cyc, 32'd1);
                end
                default: begin
                    do_cr(a, d, cyc);
                    check($sformatf("rnd%0d_cr_data", i), d, ram_m[a]);
                    check($sformatf("rnd%0d_cr_cycles", i), cyc, 32'd3);
                end
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check("rnd_no_error", {31'b0, monitor_error}, 32'h0);

        // Asynchronous reset clears every output register.
        @(negedge clk);
        jdo = ja(8'h05, 1'b1, 1'b0); ta = 1'b1;
        @(negedge clk);
        ta = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst_mon", MonDReg, 32'h0);
        check("arst_ready", {31'b0, monitor_ready}, 32'h0);
        check("arst_avrd", av_readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        do_pulse(OP_A, ja(8'h05, 1'b1, 1'b0), rdy);
        check("arst_ram_kept", MonDReg, ram_m[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
